// File: rtl/fb_pkg.sv
// Framebuffer port constants and the scanout datapath types shared by the scanout block.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_WORDS  = 98304;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scanState_t;

    // One buffered pixel: the word read from the framebuffer plus its raster tags.
    typedef struct packed {
        logic [FB_DATA_W-1:0] data;
        logic                 sof;
        logic                 eol;
    } pixelEntry_t;

    localparam int unsigned PIXEL_ENTRY_W = $bits(pixelEntry_t);

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned ctrWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Small synchronous FIFO holding pixels between the framebuffer read and the consumer.
module scanout_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = PIXEL_ENTRY_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      pushData,
    input  logic                   pop,
    output logic [DATA_W-1:0]      popData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtrQ;
    logic [PTR_W-1:0]  rdPtrQ;
    logic [PTR_W:0]    countQ;
    logic              doPush;
    logic              doPop;

    assign doPop  = pop && (countQ != '0);
    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign doPush = push && ((countQ != FULL_COUNT) || doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrQ] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + 1'b1;
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    assign popData = mem[rdPtrQ];
    assign count   = countQ;
    assign empty   = (countQ == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster-order read master for the framebuffer port: issues one read per pixel under a
// FIFO credit limit and streams the returned words out with start-of-frame/end-of-line tags.
module framebuffer_scanout
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frameStart,
    output logic                 busy,
    output logic                 frameDone,
    output logic [FB_ADDR_W-1:0] fbAddress,
    output logic                 fbReadEnable,
    input  logic [FB_DATA_W-1:0] fbDataOut,
    output logic [FB_DATA_W-1:0] pixelData,
    output logic                 pixelValid,
    input  logic                 pixelReady,
    output logic                 pixelStartOfFrame,
    output logic                 pixelEndOfLine
);

    localparam int unsigned X_W   = ctrWidth(WIDTH);
    localparam int unsigned Y_W   = ctrWidth(HEIGHT);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [X_W-1:0]       X_LAST     = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]       Y_LAST     = Y_W'(HEIGHT - 1);
    localparam logic [FB_ADDR_W-1:0] BASE       = FB_ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W:0]       CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    scanState_t           stateQ;
    logic [FB_ADDR_W-1:0] indexQ;
    logic [X_W-1:0]       xQ;
    logic [Y_W-1:0]       yQ;
    logic                 inFlightQ;
    logic                 sofQ;
    logic                 eolQ;
    logic                 busyQ;
    logic                 frameDoneQ;

    logic [CNT_W-1:0]     fifoCount;
    logic [CNT_W-1:0]     countNext;
    logic [CNT_W:0]       credit;
    logic                 fifoEmpty;
    logic                 issue;
    logic                 lastPixel;
    logic                 popFire;
    pixelEntry_t          pushEntry;
    pixelEntry_t          headEntry;

    // Occupied plus reserved slots; a read is only issued if its data is guaranteed a slot.
    assign credit    = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inFlightQ};
    assign issue     = (stateQ == SCAN) && (credit < CREDIT_MAX);
    assign lastPixel = (xQ == X_LAST) && (yQ == Y_LAST);
    assign popFire   = pixelValid && pixelReady;
    assign countNext = fifoCount + CNT_W'(inFlightQ) - CNT_W'(popFire);

    assign pushEntry = '{data: fbDataOut, sof: sofQ, eol: eolQ};

    scanout_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PIXEL_ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inFlightQ),
        .pushData (pushEntry),
        .pop      (popFire),
        .popData  (headEntry),
        .count    (fifoCount),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= IDLE;
            indexQ     <= '0;
            xQ         <= '0;
            yQ         <= '0;
            inFlightQ  <= 1'b0;
            sofQ       <= 1'b0;
            eolQ       <= 1'b0;
            busyQ      <= 1'b0;
            frameDoneQ <= 1'b0;
        end else begin
            inFlightQ  <= issue;
            frameDoneQ <= 1'b0;
            if (issue) begin
                sofQ <= (xQ == '0) && (yQ == '0);
                eolQ <= (xQ == X_LAST);
            end

            case (stateQ)
                IDLE: begin
                    if (frameStart) begin
                        stateQ <= SCAN;
                        busyQ  <= 1'b1;
                        indexQ <= '0;
                        xQ     <= '0;
                        yQ     <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (lastPixel) begin
                            // Park the address at the frame base once the last read is out.
                            stateQ <= DRAIN;
                            indexQ <= '0;
                            xQ     <= '0;
                            yQ     <= '0;
                        end else begin
                            indexQ <= indexQ + 1'b1;
                            if (xQ == X_LAST) begin
                                xQ <= '0;
                                yQ <= yQ + 1'b1;
                            end else begin
                                xQ <= xQ + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Raise frameDone for the cycle in which the FIFO is already empty and
                    // nothing is in flight; the state leaves DRAIN at the end of that cycle.
                    if (frameDoneQ) begin
                        stateQ <= IDLE;
                    end else if (countNext == '0) begin
                        frameDoneQ <= 1'b1;
                        busyQ      <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busyQ;
    assign frameDone    = frameDoneQ;
    assign fbAddress    = BASE + indexQ;
    assign fbReadEnable = issue;

    assign pixelValid        = !fifoEmpty;
    assign pixelData         = pixelValid ? headEntry.data : '0;
    assign pixelStartOfFrame = pixelValid && headEntry.sof;
    assign pixelEndOfLine    = pixelValid && headEntry.eol;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout on a 4x2 frame at base 0x100, with a
// framebuffer model returning word[a] = a one cycle after each read strobe.
module tb_framebuffer_scanout;

    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned BASE  = 'h100;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NPIX  = W * H;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frameStart = 1'b0;
    logic        pixelReady = 1'b0;
    logic        busy;
    logic        frameDone;
    logic [16:0] fbAddress;
    logic        fbReadEnable;
    logic [15:0] fbDataOut;
    logic [15:0] pixelData;
    logic        pixelValid;
    logic        pixelStartOfFrame;
    logic        pixelEndOfLine;

    int   nChecks = 0;
    int   nFails = 0;
    exp_t sbQueue[$];
    int   occ = 0;
    logic prevRe = 1'b0;
    int   readCount = 0;

    logic        reqValid = 1'b0;
    logic [16:0] reqAddr = '0;

    framebuffer_scanout #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frameStart        (frameStart),
        .busy              (busy),
        .frameDone         (frameDone),
        .fbAddress         (fbAddress),
        .fbReadEnable      (fbReadEnable),
        .fbDataOut         (fbDataOut),
        .pixelData         (pixelData),
        .pixelValid        (pixelValid),
        .pixelReady        (pixelReady),
        .pixelStartOfFrame (pixelStartOfFrame),
        .pixelEndOfLine    (pixelEndOfLine)
    );

    always #5 clk = ~clk;

    // Framebuffer model: request captured mid-cycle, data returned after the next edge.
    always @(negedge clk) begin
        reqValid = fbReadEnable;
        reqAddr  = fbAddress;
    end

    always @(posedge clk) begin
        fbDataOut <= reqValid ? reqAddr[15:0] : 16'hDEAD;
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        if (reset) begin
            occ    = 0;
            prevRe = 1'b0;
        end else begin
            hs = pixelValid && pixelReady;
            nChecks++;
            if (pixelValid !== (occ > 0)) begin
                nFails++;
                $display("FAIL valid_vs_occupancy: pixelValid=%b bench occupancy=%0d", pixelValid, occ);
            end
            if (fbReadEnable === 1'b1) begin
                nChecks++;
                if (occ + int'(prevRe) >= DEPTH) begin
                    nFails++;
                    $display("FAIL read_credit: read issued with count+inFlight=%0d, limit %0d",
                             occ + int'(prevRe), DEPTH);
                end
                nChecks++;
                if (fbAddress < 17'(BASE) || fbAddress > 17'(BASE + NPIX - 1)) begin
                    nFails++;
                    $display("FAIL read_addr_range: got %h required %h..%h", fbAddress, BASE,
                             BASE + NPIX - 1);
                end
                nChecks++;
                if (readCount >= NPIX || busy !== 1'b1) begin
                    nFails++;
                    $display("FAIL read_outside_scan: read #%0d busy=%b", readCount, busy);
                end
                readCount++;
            end
            if (hs) begin
                nChecks++;
                if (sbQueue.size() == 0) begin
                    nFails++;
                    $display("FAIL pixel_unexpected: got %h with no pixel expected", pixelData);
                end else begin
                    e = sbQueue.pop_front();
                    if ({pixelData, pixelStartOfFrame, pixelEndOfLine} !== e) begin
                        nFails++;
                        $display("FAIL pixel_stream: got data=%h sof=%b eol=%b required data=%h sof=%b eol=%b",
                                 pixelData, pixelStartOfFrame, pixelEndOfLine, e.data, e.sof, e.eol);
                    end
                end
            end
            occ    = occ + int'(prevRe) - int'(hs);
            prevRe = fbReadEnable;
        end
    end

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.data = 16'(BASE + i);
            e.sof  = (i == 0);
            e.eol  = ((i % W) == (W - 1));
            sbQueue.push_back(e);
        end
        readCount = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b required 0", busy); end
        nChecks++; if (frameDone !== 1'b0) begin nFails++; $display("FAIL reset_frameDone: got %b required 0", frameDone); end
        nChecks++; if (fbReadEnable !== 1'b0) begin nFails++; $display("FAIL reset_readEnable: got %b required 0", fbReadEnable); end
        nChecks++; if (fbAddress !== 17'(BASE)) begin nFails++; $display("FAIL reset_address: got %h required %h", fbAddress, BASE); end
        nChecks++; if (pixelValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b required 0", pixelValid); end
        nChecks++; if (pixelData !== 16'h0) begin nFails++; $display("FAIL reset_data: got %h required 0", pixelData); end
        nChecks++; if (pixelStartOfFrame !== 1'b0) begin nFails++; $display("FAIL reset_sof: got %b required 0", pixelStartOfFrame); end
        nChecks++; if (pixelEndOfLine !== 1'b0) begin nFails++; $display("FAIL reset_eol: got %b required 0", pixelEndOfLine); end
    endtask

    task automatic test_full_rate();
        int   hs = 0;
        int   firstHs = -1;
        int   lastHs = -1;
        int   doneCyc = -1;
        int   nDone = 0;
        int   bubbles = 0;
        logic busyPrev = 1'b0;
        logic busyAtDone = 1'b1;
        logic busyBeforeDone = 1'b0;
        @(posedge clk); #1;
        pixelReady = 1'b1;
        frameStart = 1'b1;
        push_expected();
        @(posedge clk); #1;
        frameStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pixelValid && pixelReady) begin
                if (firstHs < 0) firstHs = c;
                lastHs = c;
                hs++;
            end else if (hs > 0 && hs < NPIX) begin
                bubbles++;
            end
            if (frameDone) begin
                nDone++;
                if (doneCyc < 0) begin
                    doneCyc        = c;
                    busyAtDone     = busy;
                    busyBeforeDone = busyPrev;
                end
            end
            busyPrev = busy;
            if (doneCyc >= 0 && c >= doneCyc + 3) break;
        end
        nChecks++; if (hs != NPIX) begin nFails++; $display("FAIL full_rate_count: got %0d pixels required %0d", hs, NPIX); end
        nChecks++; if (firstHs != 2) begin nFails++; $display("FAIL full_rate_latency: first pixel at %0d required 2", firstHs); end
        nChecks++; if (bubbles != 0) begin nFails++; $display("FAIL full_rate_bubbles: got %0d required 0", bubbles); end
        nChecks++; if (nDone != 1) begin nFails++; $display("FAIL full_rate_done_count: got %0d required 1", nDone); end
        nChecks++; if (doneCyc != lastHs + 1) begin nFails++; $display("FAIL full_rate_done_timing: got %0d required %0d", doneCyc, lastHs + 1); end
        nChecks++; if (busyBeforeDone !== 1'b1 || busyAtDone !== 1'b0) begin
            nFails++; $display("FAIL full_rate_busy: before=%b at=%b required 1 then 0", busyBeforeDone, busyAtDone);
        end
        nChecks++; if (sbQueue.size() != 0) begin nFails++; $display("FAIL full_rate_leftover: %0d pixels missing", sbQueue.size()); end
    endtask

    task automatic test_backpressure();
        int   hs = 0;
        int   nDone = 0;
        int   doneCyc = -1;
        int   stallChecks = 0;
        logic stalled = 1'b0;
        logic [17:0] held = '0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            frameStart = (k == 0);
            pixelReady = ((k % 3) == 0);
            if (k == 0) push_expected();
            @(negedge clk);
            if (stalled) begin
                stallChecks++;
                nChecks++;
                if (pixelValid !== 1'b1 || {pixelData, pixelStartOfFrame, pixelEndOfLine} !== held) begin
                    nFails++;
                    $display("FAIL stall_hold: got valid=%b word=%h required valid=1 word=%h",
                             pixelValid, {pixelData, pixelStartOfFrame, pixelEndOfLine}, held);
                end
            end
            stalled = pixelValid && !pixelReady;
            held    = {pixelData, pixelStartOfFrame, pixelEndOfLine};
            if (pixelValid && pixelReady) hs++;
            if (frameDone) begin
                nDone++;
                if (doneCyc < 0) doneCyc = k;
            end
            if (doneCyc >= 0 && k >= doneCyc + 3) break;
        end
        nChecks++; if (hs != NPIX) begin nFails++; $display("FAIL backpressure_count: got %0d required %0d", hs, NPIX); end
        nChecks++; if (nDone != 1) begin nFails++; $display("FAIL backpressure_done: got %0d required 1", nDone); end
        nChecks++; if (stallChecks == 0) begin nFails++; $display("FAIL backpressure_no_stall: got 0 stalls required >0"); end
        nChecks++; if (sbQueue.size() != 0) begin nFails++; $display("FAIL backpressure_leftover: %0d pixels missing", sbQueue.size()); end
    endtask

    task automatic test_stall();
        int   reads = 0;
        int   firstAddr = -1;
        int   nDone = 0;
        int   doneCyc = -1;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            frameStart = (k == 0);
            pixelReady = 1'b0;
            if (k == 0) push_expected();
            @(negedge clk);
            if (fbReadEnable) reads++;
        end
        nChecks++; if (reads != DEPTH) begin nFails++; $display("FAIL stall_reads: got %0d required %0d", reads, DEPTH); end
        nChecks++; if (fbReadEnable !== 1'b0) begin nFails++; $display("FAIL stall_read_stopped: got %b required 0", fbReadEnable); end
        nChecks++; if (pixelValid !== 1'b1 || pixelData !== 16'(BASE)) begin
            nFails++; $display("FAIL stall_head: got valid=%b data=%h required 1 %h", pixelValid, pixelData, BASE);
        end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            pixelReady = 1'b1;
            @(negedge clk);
            if (fbReadEnable && firstAddr < 0) firstAddr = int'(fbAddress);
            if (frameDone) begin
                nDone++;
                if (doneCyc < 0) doneCyc = k;
            end
            if (doneCyc >= 0 && k >= doneCyc + 3) break;
        end
        nChecks++; if (firstAddr != BASE + DEPTH) begin nFails++; $display("FAIL stall_resume_addr: got %h required %h", firstAddr, BASE + DEPTH); end
        nChecks++; if (nDone != 1) begin nFails++; $display("FAIL stall_done: got %0d required 1", nDone); end
        nChecks++; if (sbQueue.size() != 0) begin nFails++; $display("FAIL stall_leftover: %0d pixels missing", sbQueue.size()); end
    endtask

    task automatic test_back_to_back();
        int   hs = 0;
        int   nDone = 0;
        int   ignoredCyc = -1;
        int   hsAtDone1 = -1;
        int   doneAtDone1 = -1;
        int   doneCyc2 = -1;
        logic busyAfterIgnored = 1'b1;
        logic busyAfterRestart = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            pixelReady = 1'b1;
            frameStart = 1'b0;
            if (k == 0) begin
                frameStart = 1'b1;
                push_expected();
            end
            if (k == 4) frameStart = 1'b1;
            if (frameDone === 1'b1 && ignoredCyc < 0) begin
                frameStart = 1'b1;
                ignoredCyc = k;
            end else if (ignoredCyc >= 0 && k == ignoredCyc + 1) begin
                frameStart = 1'b1;
                push_expected();
            end
            @(negedge clk);
            if (pixelValid && pixelReady) hs++;
            if (frameDone) nDone++;
            if (k == ignoredCyc) begin
                hsAtDone1   = hs;
                doneAtDone1 = nDone;
            end
            if (ignoredCyc >= 0 && k == ignoredCyc + 1) busyAfterIgnored = busy;
            if (ignoredCyc >= 0 && k == ignoredCyc + 2) busyAfterRestart = busy;
            if (nDone == 2 && doneCyc2 < 0) doneCyc2 = k;
            if (doneCyc2 >= 0 && k >= doneCyc2 + 3) break;
        end
        nChecks++; if (ignoredCyc < 0) begin nFails++; $display("FAIL restart_first_done: got no frameDone required one"); end
        nChecks++; if (hsAtDone1 != NPIX || doneAtDone1 != 1) begin
            nFails++; $display("FAIL restart_first_frame: got %0d pixels %0d done required %0d and 1", hsAtDone1, doneAtDone1, NPIX);
        end
        nChecks++; if (busyAfterIgnored !== 1'b0) begin nFails++; $display("FAIL restart_done_cycle_ignored: busy=%b required 0", busyAfterIgnored); end
        nChecks++; if (busyAfterRestart !== 1'b1) begin nFails++; $display("FAIL restart_new_frame: busy=%b required 1", busyAfterRestart); end
        nChecks++; if (hs != 2 * NPIX || nDone != 2) begin
            nFails++; $display("FAIL restart_totals: got %0d pixels %0d done required %0d and 2", hs, nDone, 2 * NPIX);
        end
        nChecks++; if (sbQueue.size() != 0) begin nFails++; $display("FAIL restart_leftover: %0d pixels missing", sbQueue.size()); end
    endtask

    task automatic test_reset_midframe();
        int   resetCyc = -1;
        int   nDone = 0;
        int   hs = 0;
        int   doneCyc = -1;
        logic sawTrigger = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            frameStart = (k == 0);
            pixelReady = 1'b1;
            reset      = 1'b0;
            if (k == 0) push_expected();
            if (sawTrigger && resetCyc < 0) begin
                reset    = 1'b1;
                resetCyc = k;
                sbQueue.delete();
            end
            @(negedge clk);
            if (!reset && pixelValid && pixelReady && pixelData == 16'(BASE + 2)) sawTrigger = 1'b1;
            if (frameDone) nDone++;
            if (resetCyc >= 0 && k == resetCyc + 1) begin
                nChecks++;
                if (pixelValid !== 1'b0 || busy !== 1'b0 || fbAddress !== 17'(BASE) ||
                    fbReadEnable !== 1'b0 || frameDone !== 1'b0) begin
                    nFails++;
                    $display("FAIL midreset_state: valid=%b busy=%b addr=%h re=%b done=%b required 0 0 %h 0 0",
                             pixelValid, busy, fbAddress, fbReadEnable, frameDone, BASE);
                end
            end
            if (resetCyc >= 0 && k >= resetCyc + 12) break;
        end
        nChecks++; if (resetCyc < 0) begin nFails++; $display("FAIL midreset_trigger: pixel %h never seen", BASE + 2); end
        nChecks++; if (nDone != 0) begin nFails++; $display("FAIL midreset_no_done: got %0d required 0", nDone); end
        nDone = 0;
        @(posedge clk); #1;
        frameStart = 1'b1;
        push_expected();
        @(posedge clk); #1;
        frameStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pixelValid && pixelReady) hs++;
            if (frameDone) begin
                nDone++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (doneCyc >= 0 && c >= doneCyc + 3) break;
        end
        nChecks++; if (hs != NPIX || nDone != 1) begin
            nFails++; $display("FAIL midreset_fresh_frame: got %0d pixels %0d done required %0d and 1", hs, nDone, NPIX);
        end
        nChecks++; if (sbQueue.size() != 0) begin nFails++; $display("FAIL midreset_leftover: %0d pixels missing", sbQueue.size()); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_stall();
        test_back_to_back();
        test_reset_midframe();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
